readout_rr_merger: RTL and testbench
====================================

READOUT_RR_MERGER -- requirements
Module: readout_rr_merger

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of source FIFOs (2..16).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum words taken per grant (1..255).
REQ-003 SHALL have port BUS_CLK  input  1  single clock for all logic.
REQ-004 SHALL have port BUS_RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SRC_EN  input  N_SRC  per-source enable mask.
REQ-006 SHALL have port SRC_EMPTY  input  N_SRC  per-source empty flag; data valid while low (first-word-fall-through).
REQ-007 SHALL have port SRC_DATA  input  32*N_SRC  source words, source i in bits [32i+31:32i].
REQ-008 SHALL have port SRC_READ  output  N_SRC  one-cycle pop strobe per source.
REQ-009 SHALL have port FIFO_READ_NEXT_IN  input  1  downstream pop of current output word.
REQ-010 SHALL have port FIFO_EMPTY_OUT  output  1  high when no output word is available.
REQ-011 SHALL have port FIFO_DATA_OUT  output  32  current output word, valid while FIFO_EMPTY_OUT low.
REQ-012 SHALL have port GRANT_ID  output  4  index of the currently or last granted source.
REQ-013 SHALL have port READ_ERROR  output  1  one-cycle pulse on pop while empty.

Function
REQ-014 SHALL merge N_SRC FWFT sources into one FWFT stream; words pass unmodified and in per-source order.
REQ-015 SHALL use FSM states IDLE and GRANT.
REQ-016 SHALL, in IDLE, select the first index i at or after round-robin pointer PTR (wrapping at N_SRC) with SRC_EN[i]=1 and SRC_EMPTY[i]=0, then enter GRANT next cycle; stay IDLE if none.
REQ-017 SHALL, in GRANT, assert SRC_READ[g] combinationally in each cycle where SRC_EMPTY[g]=0, SRC_EN[g]=1 and the output buffer has space (counting a same-cycle downstream pop).
REQ-018 SHALL count words popped in the grant; leave GRANT to IDLE after MAX_BURST pops, when SRC_EMPTY[g]=1, or when SRC_EN[g]=0; set PTR=(g+1) mod N_SRC on exit.
REQ-019 SHALL cost exactly one idle bubble cycle per grant switch.
REQ-020 SHALL hold a 2-entry output buffer; a popped source word appears on FIFO_DATA_OUT with FIFO_EMPTY_OUT low one cycle after SRC_READ.
REQ-021 SHALL sustain 1 word/cycle within a grant while FIFO_READ_NEXT_IN is held high.
REQ-022 SHALL, on FIFO_READ_NEXT_IN with buffer non-empty, advance to the next buffered word on the following cycle; simultaneous push and pop on a full buffer SHALL be accepted.
REQ-023 SHALL ignore FIFO_READ_NEXT_IN while FIFO_EMPTY_OUT is high and pulse READ_ERROR for one cycle.
REQ-024 SHALL never assert more than one SRC_READ bit per cycle, and never assert SRC_READ for a source whose SRC_EMPTY is high.
REQ-025 SHALL, if SRC_EN[g] drops mid-grant, complete no further pops from g; words already buffered SHALL still be delivered.

Reset
REQ-026 SHALL, on BUS_RST_N low, immediately force: FSM=IDLE, PTR=0, burst count=0, buffer empty, FIFO_EMPTY_OUT=1, FIFO_DATA_OUT=0, GRANT_ID=0, READ_ERROR=0, SRC_READ=0.
REQ-027 SHALL discard buffered words on reset mid-operation; the first post-reset grant SHALL start from source 0.

Structure
REQ-028 SHALL place DATA_W=32, the FSM state type and the GRANT_ID width constant in shared package readout_pkg.
REQ-029 SHALL implement the 2-entry output buffer as sub-module readout_skid_buffer (push/pop/full/empty, async active-low reset).

Verification
REQ-030 SHALL test: N_SRC=4, all enabled, src0 holds 3 words (A0..A2), READ_NEXT held high -> SRC_READ[0] 3 cycles back-to-back, output A0,A1,A2 from cycle 2, FSM back to IDLE, PTR=1.
REQ-031 SHALL test: MAX_BURST=4, src1 and src2 each hold 6 words -> output order 4xsrc1, 4xsrc2, 2xsrc1, 2xsrc2 with one bubble per switch.
REQ-032 SHALL test: downstream READ_NEXT low for 10 cycles during a grant -> exactly 2 words popped from the source, SRC_READ low thereafter, no word lost on resume.
REQ-033 SHALL test: READ_NEXT pulse while FIFO_EMPTY_OUT=1 -> READ_ERROR high exactly one cycle, output unchanged.
REQ-034 SHALL test: SRC_EN[2] cleared mid-grant after 2 of 5 words -> no further SRC_READ[2], 2 words delivered, next grant goes to src3.
REQ-035 SHALL test: BUS_RST_N low for one cycle with 2 buffered words -> FIFO_EMPTY_OUT=1 and FIFO_DATA_OUT=0 during reset, buffered words never output, next grant from src0.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and constants for the readout round-robin merger.
// Also holds the wrap-around index helper used by the arbiter.
package readout_pkg;

    localparam int DATA_W = 32;
    localparam int GID_W  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } rr_state_t;

    function automatic logic [GID_W-1:0] wrap_add(
        input logic [GID_W-1:0] base,
        input logic [GID_W-1:0] off,
        input int unsigned      n
    );
        logic [GID_W:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= n[GID_W:0]) begin
            s = s - n[GID_W:0];
        end
        return s[GID_W-1:0];
    endfunction

endpackage

// File: rtl/readout_rr_merger_if.sv
// Push/pop link between the merger control and its output buffer.
// The merger drives pushes and pops; the buffer reports its fill state.
interface readout_rr_merger_if;
    import readout_pkg::*;

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] pop_data;

    modport master (
        output push, push_data, pop,
        input  full, empty, pop_data
    );

    modport slave (
        input  push, push_data, pop,
        output full, empty, pop_data
    );

endinterface

// File: rtl/readout_skid_buffer.sv
// Two-entry FWFT output buffer for the readout merger.
// Push and pop in the same cycle are accepted even when full.
module readout_skid_buffer
    import readout_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    readout_rr_merger_if.slave  bif
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_cnt;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = bif.pop && (r_cnt != 2'd0);
    assign w_push = bif.push && ((r_cnt != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= bif.push_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bif.full     = (r_cnt == 2'd2);
    assign bif.empty    = (r_cnt == 2'd0);
    assign bif.pop_data = (r_cnt == 2'd0) ? '0 : r_mem[r_rd];

endmodule

// File: rtl/readout_rr_merger.sv
// Round-robin merger of N_SRC FWFT source FIFOs into one FWFT stream.
// Grants are bursts of up to MAX_BURST words with one idle cycle between.
module readout_rr_merger
    import readout_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST_N,
    input  logic [N_SRC-1:0]        SRC_EN,
    input  logic [N_SRC-1:0]        SRC_EMPTY,
    input  logic [DATA_W*N_SRC-1:0] SRC_DATA,
    output logic [N_SRC-1:0]        SRC_READ,
    input  logic                    FIFO_READ_NEXT_IN,
    output logic                    FIFO_EMPTY_OUT,
    output logic [DATA_W-1:0]       FIFO_DATA_OUT,
    output logic [GID_W-1:0]        GRANT_ID,
    output logic                    READ_ERROR
);

    localparam int SRC_MAX = 1 << GID_W;
    localparam int CNT_W   = 8;

    rr_state_t          r_state;
    rr_state_t          w_state_nxt;
    logic [GID_W-1:0]   r_ptr;
    logic [GID_W-1:0]   w_ptr_nxt;
    logic [GID_W-1:0]   r_gnt;
    logic [GID_W-1:0]   w_gnt_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_rd_err;

    logic [N_SRC-1:0]   w_avail;
    logic [SRC_MAX-1:0] w_avail_x;
    logic [GID_W-1:0]   w_idx;
    logic [GID_W-1:0]   w_pick;
    logic               w_found;
    logic               w_g_ok;
    logic               w_pop_ok;
    logic               w_space;
    logic               w_take;

    readout_rr_merger_if bif ();

    readout_skid_buffer u_buf (
        .clk   (BUS_CLK),
        .rst_n (BUS_RST_N),
        .bif   (bif)
    );

    assign w_avail   = SRC_EN & ~SRC_EMPTY;
    assign w_avail_x = SRC_MAX'(w_avail);

    // Scan from the highest offset down so the lowest offset wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_idx = wrap_add(r_ptr, GID_W'(k), N_SRC);
            if (w_avail_x[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_pop_ok = FIFO_READ_NEXT_IN && !bif.empty;
    assign w_space  = !bif.full || w_pop_ok;
    assign w_g_ok   = (r_state == ST_GRANT) && w_avail_x[r_gnt];
    assign w_take   = w_g_ok && w_space;

    assign bif.push      = w_take;
    assign bif.push_data = SRC_DATA[DATA_W*int'(r_gnt) +: DATA_W];
    assign bif.pop       = w_pop_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!w_g_ok ||
                    (w_take && (r_cnt == CNT_W'(MAX_BURST - 1)))) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = wrap_add(r_gnt, GID_W'(1), N_SRC);
                    w_cnt_nxt   = '0;
                end else if (w_take) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_rd_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rd_err <= FIFO_READ_NEXT_IN && bif.empty;
        end
    end

    assign SRC_READ       = w_take ? (N_SRC'(1) << r_gnt) : '0;
    assign FIFO_EMPTY_OUT = bif.empty;
    assign FIFO_DATA_OUT  = bif.pop_data;
    assign GRANT_ID       = r_gnt;
    assign READ_ERROR     = r_rd_err;

endmodule

// File: tb/tb_readout_rr_merger.sv
// Directed bench for readout_rr_merger with FWFT source queue models.
// Table vectors cover arbitration; hand sequences cover multi-cycle cases.
module tb_readout_rr_merger;

    localparam int NS = 4;
    localparam int MB = 4;

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST_N = 1'b0;
    logic [NS-1:0]     SRC_EN;
    logic [NS-1:0]     SRC_EMPTY;
    logic [32*NS-1:0]  SRC_DATA;
    logic [NS-1:0]     SRC_READ;
    logic              FIFO_READ_NEXT_IN;
    logic              FIFO_EMPTY_OUT;
    logic [31:0]       FIFO_DATA_OUT;
    logic [3:0]        GRANT_ID;
    logic              READ_ERROR;

    always #5 BUS_CLK = ~BUS_CLK;

    readout_rr_merger #(.N_SRC(NS), .MAX_BURST(MB)) dut (
        .BUS_CLK           (BUS_CLK),
        .BUS_RST_N         (BUS_RST_N),
        .SRC_EN            (SRC_EN),
        .SRC_EMPTY         (SRC_EMPTY),
        .SRC_DATA          (SRC_DATA),
        .SRC_READ          (SRC_READ),
        .FIFO_READ_NEXT_IN (FIFO_READ_NEXT_IN),
        .FIFO_EMPTY_OUT    (FIFO_EMPTY_OUT),
        .FIFO_DATA_OUT     (FIFO_DATA_OUT),
        .GRANT_ID          (GRANT_ID),
        .READ_ERROR        (READ_ERROR)
    );

    typedef struct {
        logic [3:0]  en;
        int          src;
        logic [31:0] word;
        int          exp_n;
        logic [3:0]  exp_gid;
    } vec_t;

    logic [31:0]   q [NS][$];
    logic [NS-1:0] rd_log [$];
    logic          err_log [$];
    logic [31:0]   out_w [$];
    int            out_t [$];
    int            tc;
    int            n_tests;
    int            n_fail;
    int            viol;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ow(input int k);
        return (k < out_w.size()) ? out_w[k] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [NS-1:0] rl(input int k);
        return (k < rd_log.size()) ? rd_log[k] : {NS{1'b1}};
    endfunction

    function automatic logic el(input int k);
        return (k < err_log.size()) ? err_log[k] : 1'bx;
    endfunction

    task automatic drive_src();
        logic [NS-1:0]    e;
        logic [32*NS-1:0] d;
        d = '0;
        for (int i = 0; i < NS; i++) begin
            e[i] = (q[i].size() == 0);
            if (!e[i]) d[32*i +: 32] = q[i][0];
        end
        SRC_EMPTY = e;
        SRC_DATA  = d;
    endtask

    task automatic load(input int s, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) q[s].push_back(base + 32'(k));
        drive_src();
    endtask

    task automatic clear_logs();
        rd_log.delete();
        err_log.delete();
        out_w.delete();
        out_t.delete();
        tc = 0;
    endtask

    // Sample just after the falling edge, pop the models after the rising one.
    task automatic tick();
        logic [NS-1:0] s_rd;
        #1;
        s_rd = SRC_READ;
        rd_log.push_back(s_rd);
        err_log.push_back(READ_ERROR);
        if (FIFO_READ_NEXT_IN && !FIFO_EMPTY_OUT) begin
            out_w.push_back(FIFO_DATA_OUT);
            out_t.push_back(tc);
        end
        if ($countones(s_rd) > 1 || (s_rd & SRC_EMPTY) != '0) viol++;
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < NS; i++)
            if (s_rd[i] && q[i].size() > 0) void'(q[i].pop_front());
        drive_src();
        @(negedge BUS_CLK);
        tc++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic hard_reset();
        BUS_RST_N = 1'b0;
        for (int i = 0; i < NS; i++) q[i].delete();
        SRC_EN = '1;
        FIFO_READ_NEXT_IN = 1'b0;
        drive_src();
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        clear_logs();
    endtask

    vec_t        tv [6];
    logic [31:0] e31 [12];
    int          s;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        viol    = 0;
        tc      = 0;
        tv[0] = '{4'hF,    0, 32'h1111_0000, 1, 4'd0};
        tv[1] = '{4'hF,    3, 32'h1111_0003, 1, 4'd3};
        tv[2] = '{4'hF,    2, 32'h1111_0002, 1, 4'd2};
        tv[3] = '{4'b1011, 2, 32'h2222_0002, 0, 4'd2};
        tv[4] = '{4'b0100, 2, 32'h3333_0002, 1, 4'd2};
        tv[5] = '{4'hF,    1, 32'h1111_0001, 1, 4'd1};
        e31 = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
                32'h2000_0000, 32'h2000_0001, 32'h2000_0002, 32'h2000_0003,
                32'h1000_0004, 32'h1000_0005, 32'h2000_0004, 32'h2000_0005};

        SRC_EN = '1;
        FIFO_READ_NEXT_IN = 1'b0;
        drive_src();
        #1;
        chk("rst_empty", FIFO_EMPTY_OUT, 1);
        chk("rst_data", FIFO_DATA_OUT, 0);
        chk("rst_gid", GRANT_ID, 0);
        chk("rst_err", READ_ERROR, 0);
        chk("rst_read", SRC_READ, 0);
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        clear_logs();

        for (int v = 0; v < 6; v++) begin
            clear_logs();
            SRC_EN = tv[v].en;
            FIFO_READ_NEXT_IN = 1'b1;
            load(tv[v].src, tv[v].word, 1);
            ticks(5);
            chk($sformatf("tv%0d_cnt", v), out_w.size(), tv[v].exp_n);
            chk($sformatf("tv%0d_word", v),
                (out_w.size() > 0) ? out_w[0] : 32'h0,
                (tv[v].exp_n > 0) ? tv[v].word : 32'h0);
            chk($sformatf("tv%0d_gid", v), GRANT_ID, tv[v].exp_gid);
            q[tv[v].src].delete();
            drive_src();
            SRC_EN = '1;
        end

        // Single 3-word burst from src0, then pointer must sit at src1.
        hard_reset();
        FIFO_READ_NEXT_IN = 1'b1;
        load(0, 32'hA000_0000, 3);
        ticks(7);
        chk("b3_rd0", rl(0), 4'b0000);
        chk("b3_rd1", rl(1), 4'b0001);
        chk("b3_rd2", rl(2), 4'b0001);
        chk("b3_rd3", rl(3), 4'b0001);
        chk("b3_rd4", rl(4), 4'b0000);
        chk("b3_cnt", out_w.size(), 3);
        chk("b3_lat", (out_t.size() > 0) ? out_t[0] : -1, 2);
        for (int k = 0; k < 3; k++)
            chk($sformatf("b3_w%0d", k), ow(k), 32'hA000_0000 + 32'(k));
        load(0, 32'hB000_0000, 1);
        load(1, 32'hC000_0000, 1);
        ticks(8);
        chk("ptr_first", ow(3), 32'hC000_0000);
        chk("ptr_second", ow(4), 32'hB000_0000);

        // Burst limit interleaving between src1 and src2.
        hard_reset();
        FIFO_READ_NEXT_IN = 1'b1;
        load(1, 32'h1000_0000, 6);
        load(2, 32'h2000_0000, 6);
        ticks(22);
        chk("mb_cnt", out_w.size(), 12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("mb_w%0d", k), ow(k), e31[k]);
        chk("mb_rd4", rl(4), 4'b0010);
        chk("mb_bub5", rl(5), 4'b0000);
        chk("mb_rd6", rl(6), 4'b0100);
        chk("mb_bub10", rl(10), 4'b0000);
        chk("mb_rd11", rl(11), 4'b0010);

        // Downstream stall: buffer fills with two words, then drains.
        hard_reset();
        load(0, 32'h3000_0000, 6);
        ticks(12);
        s = 0;
        foreach (rd_log[k]) s += $countones(rd_log[k]);
        chk("bp_pops", s, 2);
        chk("bp_idle", rl(11), 4'b0000);
        #1;
        chk("bp_empty", FIFO_EMPTY_OUT, 0);
        chk("bp_head", FIFO_DATA_OUT, 32'h3000_0000);
        FIFO_READ_NEXT_IN = 1'b1;
        ticks(12);
        chk("bp_cnt", out_w.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("bp_w%0d", k), ow(k), 32'h3000_0000 + 32'(k));

        // Pop while empty.
        hard_reset();
        ticks(2);
        FIFO_READ_NEXT_IN = 1'b1;
        ticks(1);
        FIFO_READ_NEXT_IN = 1'b0;
        ticks(3);
        chk("re_pre", el(2), 1'b0);
        chk("re_pulse", el(3), 1'b1);
        chk("re_post", el(4), 1'b0);
        chk("re_empty", FIFO_EMPTY_OUT, 1);
        chk("re_data", FIFO_DATA_OUT, 0);
        chk("re_cnt", out_w.size(), 0);

        // Enable dropped mid-grant.
        hard_reset();
        FIFO_READ_NEXT_IN = 1'b1;
        load(2, 32'h4000_0000, 5);
        load(3, 32'h5000_0000, 1);
        ticks(3);
        SRC_EN = 4'b1011;
        ticks(7);
        s = 0;
        foreach (rd_log[k]) s += int'(rd_log[k][2]);
        chk("en_pops2", s, 2);
        chk("en_rd5", rl(5), 4'b1000);
        chk("en_cnt", out_w.size(), 3);
        chk("en_w0", ow(0), 32'h4000_0000);
        chk("en_w1", ow(1), 32'h4000_0001);
        chk("en_w2", ow(2), 32'h5000_0000);

        // Reset with two words sitting in the output buffer.
        hard_reset();
        load(0, 32'h6000_0000, 4);
        load(1, 32'h7000_0000, 1);
        ticks(4);
        #1;
        chk("mr_full", FIFO_EMPTY_OUT, 0);
        BUS_RST_N = 1'b0;
        #1;
        chk("mr_empty", FIFO_EMPTY_OUT, 1);
        chk("mr_data", FIFO_DATA_OUT, 0);
        chk("mr_read", SRC_READ, 0);
        chk("mr_gid", GRANT_ID, 0);
        tick();
        BUS_RST_N = 1'b1;
        FIFO_READ_NEXT_IN = 1'b1;
        clear_logs();
        ticks(10);
        chk("mr_cnt", out_w.size(), 3);
        chk("mr_w0", ow(0), 32'h6000_0002);
        chk("mr_w1", ow(1), 32'h6000_0003);
        chk("mr_w2", ow(2), 32'h7000_0000);

        chk("protocol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
